// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch queue.
package fetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  localparam int INST_BYTES = 4;
  localparam int DEF_XLEN   = 32;
  localparam int DEF_ILEN   = 32;

  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead prefetch queue of fetched instructions; flush empties it and overrides a push,
// while a pop in the same cycle is simply absorbed by the emptying.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PW      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  entry_t      push_data,
  input  logic        pop,
  input  logic        flush,
  output logic [PW:0] count,
  output entry_t      head
);

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, RUN/HALT FSM, 1-cycle imem interface and prefetch queue.
// Optional stall counter port/logic enabled by defining FETCH_STALL_CNT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter int               ILEN      = 32,
  parameter logic [XLEN-1:0]  RESET_VEC = '0,
  parameter int               DEPTH     = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [ILEN-1:0] inst_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output fetch_state_t    dbg_state
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cycles
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } entry_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] RESET_PC   = RESET_VEC & ALIGN_MASK;
  localparam int              FW         = $clog2(DEPTH) + 1;
  localparam int              CW         = FW + 1;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            issue;
  logic            credit_ok;
  logic            push;
  logic [FW-1:0]   fifo_count;
  entry_t          push_entry;
  entry_t          head;

  // Credit counts the response still due; a same-cycle pop is deliberately not credited.
  assign credit_ok = (CW'(fifo_count) + CW'(inflight_q)) < CW'(DEPTH);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    issue         = 1'b0;

    state_d = halt ? HALT : RUN;
    issue   = !reset && (state_d == RUN) && !redirect_valid && credit_ok;

    if (redirect_valid) begin
      pc_d = redirect_pc & ALIGN_MASK;
    end else if (issue) begin
      pc_d = pc_q + XLEN'(INST_BYTES);
    end

    if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign imem_req  = issue;
  assign imem_addr = pc_q;

  // A redirect in the response cycle discards the word fetched down the old path.
  assign push            = inflight_q && !redirect_valid;
  assign push_entry.pc   = inflight_pc_q;
  assign push_entry.inst = imem_rdata;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (inst_ready),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .head      (head)
  );

  // Decode handshake: an instruction transfers on a posedge where inst_valid && inst_ready;
  // while inst_valid && !inst_ready the head (inst_pc/inst_data) holds unchanged.
  assign inst_valid = (fifo_count != '0);
  assign inst_pc    = head.pc;
  assign inst_data  = head.inst;
  assign dbg_state  = state_q;

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (((state_d == HALT) || (!redirect_valid && !credit_ok)) && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected PCs queued by the driver, checked by a delivery monitor.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          XLEN  = 32;
  localparam int          ILEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RVEC  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  fetch_state_t dbg_state;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN      (XLEN),
    .ILEN      (ILEN),
    .RESET_VEC (RVEC),
    .DEPTH     (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .dbg_state      (dbg_state)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 3) ^ 32'hA5A5_5A5A;
  endfunction

  // Instruction memory model: data appears the cycle after the request.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic exp_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted instruction must be the next expected PC with its memory word.
  always @(negedge clk) begin
    if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_inst: got pc %08h expected none", inst_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("inst_pc", inst_pc, e);
        chk("inst_data", inst_data, mem_word(e));
      end
    end
  end

  initial begin
    reset = 1'b1; inst_ready = 1'b1; halt = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    adv(); adv();
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_data", inst_data, 32'd0);
`ifdef FETCH_STALL_CNT_EN
    chk("rst_stall", stall_cycles, 32'd0);
`endif

    // Test 1: sequential fetch from RESET_VEC (cycles 0..9).
    adv(); reset = 1'b0;
    exp_run(32'h100, 8);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t1_req", 32'(imem_req), 32'd1);
      chk("t1_addr", imem_addr, 32'h100 + 32'(4 * k));
      chk("t1_valid", 32'(inst_valid), 32'(k >= 2));
      adv();
    end

    // Test 2: decode back-pressure fills the queue (cycles 10..19).
    inst_ready = 1'b0;
    for (int k = 10; k < 20; k++) begin
      @(negedge clk);
      if (k < 12) begin
        chk("t2_req", 32'(imem_req), 32'd1);
        chk("t2_addr", imem_addr, 32'h128 + 32'(4 * (k - 10)));
      end else begin
        chk("t2_req_blocked", 32'(imem_req), 32'd0);
      end
      chk("t2_valid", 32'(inst_valid), 32'd1);
      chk("t2_head_pc", inst_pc, 32'h120);
      adv();
    end
    exp_run(32'h120, 9);
    inst_ready = 1'b1;
    @(negedge clk);
    chk("t2_pop_no_credit", 32'(imem_req), 32'd0);
    adv();
    @(negedge clk);
    chk("t2_resume_req", 32'(imem_req), 32'd1);
    chk("t2_resume_addr", imem_addr, 32'h130);
    repeat (7) adv();

    // Test 3: redirect with a response in flight (cycle 28).
    redirect_valid = 1'b1; redirect_pc = 32'h2003;
    @(negedge clk);
    chk("t3_req_redirect", 32'(imem_req), 32'd0);
    adv();
    redirect_valid = 1'b0;
    exp_run(32'h2000, 9);
    @(negedge clk);
    chk("t3_valid_after", 32'(inst_valid), 32'd0);
    chk("t3_req", 32'(imem_req), 32'd1);
    chk("t3_addr", imem_addr, 32'h2000);
    adv();
    @(negedge clk);
    chk("t3_valid_after2", 32'(inst_valid), 32'd0);
    chk("t3_addr2", imem_addr, 32'h2004);
    repeat (4) adv();

    // Test 4: halt for 5 cycles with a response in flight (cycles 34..38).
    halt = 1'b1; inst_ready = 1'b0;
    for (int k = 34; k < 39; k++) begin
      @(negedge clk);
      chk("t4_req", 32'(imem_req), 32'd0);
      chk("t4_valid", 32'(inst_valid), 32'd1);
      chk("t4_head_pc", inst_pc, 32'h200C);
      chk("t4_state", 32'(dbg_state), (k > 34) ? 32'(HALT) : 32'(RUN));
`ifdef FETCH_STALL_CNT_EN
      if (k == 34) chk("t4_stall_before", stall_cycles, 32'd9);
`endif
      adv();
    end
    halt = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    chk("t4_resume_req", 32'(imem_req), 32'd1);
    chk("t4_resume_addr", imem_addr, 32'h2014);
`ifdef FETCH_STALL_CNT_EN
    chk("t4_stall_after", stall_cycles, 32'd14);
`endif
    repeat (5) adv();

    // Test 5: wrap-around of the PC (redirect at cycle 44).
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    chk("t5_req_redirect", 32'(imem_req), 32'd0);
    adv();
    redirect_valid = 1'b0;
    exp_run(32'hFFFF_FFF8, 4);
    @(negedge clk);
    chk("t5_valid", 32'(inst_valid), 32'd0);
    chk("t5_addr0", imem_addr, 32'hFFFF_FFF8);
    adv();
    @(negedge clk);
    chk("t5_addr1", imem_addr, 32'hFFFF_FFFC);
    adv();
    @(negedge clk);
    chk("t5_addr2", imem_addr, 32'h0000_0000);
    chk("t5_req2", 32'(imem_req), 32'd1);
    repeat (4) adv();

    // Test 6: reset with a full queue (fill 51..54, reset 55..56).
    inst_ready = 1'b0;
    repeat (3) adv();
    @(negedge clk);
    chk("t6_full_req", 32'(imem_req), 32'd0);
    chk("t6_full_pc", inst_pc, 32'h8);
    adv();
    reset = 1'b1;
    @(negedge clk);
    chk("t6_req_in_reset", 32'(imem_req), 32'd0);
    adv();
    @(negedge clk);
    chk("t6_valid", 32'(inst_valid), 32'd0);
    chk("t6_req", 32'(imem_req), 32'd0);
    chk("t6_pc", inst_pc, 32'd0);
    chk("t6_data", inst_data, 32'd0);
`ifdef FETCH_STALL_CNT_EN
    chk("t6_stall", stall_cycles, 32'd0);
`endif
    adv();
    reset = 1'b0; inst_ready = 1'b1;
    exp_run(RVEC, 3);
    @(negedge clk);
    chk("t6_restart_req", 32'(imem_req), 32'd1);
    chk("t6_restart_addr", imem_addr, RVEC);
    repeat (5) adv();
    inst_ready = 1'b0;
    @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
